ysyx_210238_sync_fifo: RTL and testbench

Parameterised multi-entry synchronous FIFO with first-word-fall-through (FWFT) read port. Provides write-side back-pressure (full, almost_full) and read-side occupancy (empty, count), which the single-entry buffer lacks. Buffers outstanding bus requests and responses between the core pipeline and the AXI bridge when more than one transaction is in flight.

---
 rtl/ysyx_210238_sync_fifo.sv | 102 ++++++++++
 tb/tb_ysyx_210238_sync_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210238_sync_fifo.sv
// Multi-entry synchronous FIFO with a first-word-fall-through read port.
// It buffers in-flight bus requests and responses between the core and the
// AXI bridge. It reports back-pressure (full, almost_full), occupancy (empty,
// count), and one-cycle pulses when a write is dropped or a read is ignored.
module ysyx_210238_sync_fifo #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AF_LEVEL   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write,
  input  logic [FIFO_WIDTH-1:0]       fifo_in,
  input  logic                        read,
  output logic [FIFO_WIDTH-1:0]       fifo_out,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic                        almost_full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [CntW-1:0]       w_count_next;

  // A pop on a full FIFO frees a slot in the same cycle. A pop on an empty FIFO
  // is never accepted, so an incoming write does not bypass the storage.
  assign w_push_ok = write && (!r_full || read);
  assign w_pop_ok  = read && !r_empty;

  // Work out the next occupancy. Every flag is registered from this value.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CntW'(1);
      2'b01:   w_count_next = r_count - CntW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Update the storage and pointers. Popped entries are left in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= fifo_in;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
    end
  end

  // Register the occupancy, the status flags and the error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_empty       <= (w_count_next == '0);
      r_full        <= (w_count_next == CntW'(FIFO_DEPTH));
      r_almost_full <= (w_count_next >= CntW'(AF_LEVEL));
      r_overflow    <= write && !w_push_ok;
      r_underflow   <= read && r_empty;
    end
  end

  assign fifo_out    = r_mem[r_rd_ptr];
  assign fifo_empty  = r_empty;
  assign fifo_full   = r_full;
  assign almost_full = r_almost_full;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_ysyx_210238_sync_fifo.sv
// Self-checking bench for ysyx_210238_sync_fifo. A queue models the FIFO
// contents. Inputs are driven 1 time unit after the rising clock edge, and
// outputs are sampled 1 time unit after the following edge.
module tb_ysyx_210238_sync_fifo;

  localparam int Depth = 4;
  localparam int AfLvl = 3;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [31:0] fifo_in;
  logic        read;
  logic [31:0] fifo_out;
  logic        fifo_empty;
  logic        fifo_full;
  logic        almost_full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int          n_cmp;
  int          n_bad;
  logic [31:0] q[$];
  logic        exp_ovf;
  logic        exp_udf;

  ysyx_210238_sync_fifo #(
    .FIFO_WIDTH(32),
    .FIFO_DEPTH(Depth),
    .AF_LEVEL  (AfLvl)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .fifo_in    (fifo_in),
    .read       (read),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and advance the reference model.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    int          n;
    logic        push_ok;
    logic        pop_ok;
    logic [31:0] dummy;
    n       = q.size();
    push_ok = w && (n < Depth || r);
    pop_ok  = r && (n > 0);
    exp_ovf = w && !push_ok;
    exp_udf = r && (n == 0);
    write   = w;
    fifo_in = d;
    read    = r;
    @(posedge clk);
    #1;
    if (pop_ok) dummy = q.pop_front();
    if (push_ok) q.push_back(d);
    write   = 1'b0;
    read    = 1'b0;
    fifo_in = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (fifo_full !== 1'b0 || almost_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_full_af: got %b%b want 00", fifo_full, almost_full);
    end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b%b want 00", overflow, underflow);
    end
    n_cmp++; if (fifo_out !== 32'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", fifo_out); end
  endtask

  task automatic fill4();
    logic [31:0] vals[4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vals[i], 1'b0);
      n_cmp++; if (int'(count) !== i + 1) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= AfLvl)) begin
        n_bad++; $display("FAIL fill_af: got %b want %b", almost_full, (i + 1 >= AfLvl));
      end
      n_cmp++; if (fifo_full !== (i == 3)) begin n_bad++; $display("FAIL fill_full: got %b want %b", fifo_full, (i == 3)); end
      n_cmp++; if (fifo_out !== 32'h11) begin n_bad++; $display("FAIL fill_out: got %h want 11", fifo_out); end
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 2 * Depth) begin
      n_cmp++; if (fifo_out !== q[0]) begin n_bad++; $display("FAIL %s_out: got %h want %h", tag, fifo_out, q[0]); end
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    n_cmp++; if (fifo_empty !== 1'b1 || count !== 3'd0) begin
      n_bad++; $display("FAIL %s_empty: got empty=%b count=%0d want 1/0", tag, fifo_empty, count);
    end
  endtask

  task automatic test_fill();
    fill4();
  endtask

  task automatic test_overflow();
    logic [31:0] exp[4];
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    cycle(1'b1, 32'h55, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (fifo_out !== exp[i]) begin n_bad++; $display("FAIL ovf_drain: got %h want %h", fifo_out, exp[i]); end
      cycle(1'b0, '0, 1'b1);
      if (i == 0) begin
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
      end
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_full_push_pop();
    fill4();
    cycle(1'b1, 32'h66, 1'b1);
    n_cmp++; if (count !== 3'd4 || fifo_full !== 1'b1) begin
      n_bad++; $display("FAIL fullpp_state: got count=%0d full=%b want 4/1", count, fifo_full);
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpp_ovf: got %b want 0", overflow); end
    n_cmp++; if (fifo_out !== 32'h22) begin n_bad++; $display("FAIL fullpp_out: got %h want 22", fifo_out); end
    n_cmp++; if (q[Depth-1] !== 32'h66) begin n_bad++; $display("FAIL fullpp_model: got %h want 66", q[Depth-1]); end
    drain("fullpp");
  endtask

  task automatic test_underflow();
    cycle(1'b1, 32'hA5, 1'b1);
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL udf_pulse: got %b want 1", underflow); end
    n_cmp++; if (fifo_empty !== 1'b0 || count !== 3'd1) begin
      n_bad++; $display("FAIL udf_state: got empty=%b count=%0d want 0/1", fifo_empty, count);
    end
    n_cmp++; if (fifo_out !== 32'hA5) begin n_bad++; $display("FAIL udf_out: got %h want a5", fifo_out); end
    cycle(1'b0, '0, 1'b0);
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL udf_one_cycle: got %b want 0", underflow); end
    drain("udf");
  endtask

  task automatic test_wrap();
    cycle(1'b1, 32'hF0, 1'b0);
    cycle(1'b1, 32'hF1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (fifo_out !== q[0]) begin n_bad++; $display("FAIL wrap_out: got %h want %h", fifo_out, q[0]); end
      cycle(1'b1, 32'h100 + 32'(i), 1'b1);
      n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", count); end
    end
    n_cmp++; if (fifo_out !== 32'h108) begin n_bad++; $display("FAIL wrap_head: got %h want 108", fifo_out); end
    drain("wrap");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0);
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL arst_pre: got %0d want 3", count); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || fifo_empty !== 1'b1) begin
      n_bad++; $display("FAIL arst_state: got count=%0d empty=%b want 0/1", count, fifo_empty);
    end
    n_cmp++; if (fifo_out !== 32'h0) begin n_bad++; $display("FAIL arst_out: got %h want 0", fifo_out); end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h77, 1'b0);
    n_cmp++; if (fifo_out !== 32'h77 || count !== 3'd1) begin
      n_bad++; $display("FAIL arst_after: got out=%h count=%0d want 77/1", fifo_out, count);
    end
    drain("arst");
  endtask

  task automatic test_random();
    logic        w;
    logic        r;
    logic [31:0] d;
    int          n;
    for (int i = 0; i < 400; i++) begin
      // Bias phases toward filling or draining so both boundaries are hit.
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      d = $urandom;
      cycle(w, d, r);
      n = q.size();
      n_cmp++;
      if (int'(count) !== n || fifo_empty !== (n == 0) || fifo_full !== (n == Depth) ||
          almost_full !== (n >= AfLvl) || overflow !== exp_ovf || underflow !== exp_udf ||
          (n > 0 && fifo_out !== q[0])) begin
        n_bad++;
        $display("FAIL rand_cycle%0d: got cnt=%0d e=%b f=%b af=%b ov=%b ud=%b out=%h want cnt=%0d ov=%b ud=%b out=%h",
                 i, count, fifo_empty, fifo_full, almost_full, overflow, underflow, fifo_out,
                 n, exp_ovf, exp_udf, (n > 0) ? q[0] : 32'h0);
      end
    end
    drain("rand");
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    fifo_in = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
